// File: rtl/uncached_write_buffer.sv
// rtl/uncached_write_buffer.sv - posted single-beat AXI3 write buffer with read ordering gate
//
// Accepts single-beat CPU writes into a DEPTH-entry FIFO, answers them with an
// immediate OKAY B response, and drains them downstream one at a time.
// Reads pass through only when no write is buffered or in flight, and writes
// stay blocked while a read burst is outstanding.
//
// Ports:
//   aclk, reset             clock and synchronous active-high reset
//   s_aw*/s_w*/s_b*         CPU-side write channels (s_wid, s_awlen unused)
//   s_ar*/s_r*              CPU-side read channels
//   m_aw*/m_w*/m_b*         downstream write channels, m_bready tied high
//   m_ar*/m_r*              downstream read channels
//   wb_empty                nothing buffered, nothing outstanding
//   wr_err                  one-cycle pulse on a non-OKAY downstream response
module uncached_write_buffer #(
    parameter int BUS_WIDTH = 4,
    parameter int DEPTH     = 4
) (
    input  logic                 aclk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] s_awid,
    input  logic [31:0]          s_awaddr,
    input  logic [3:0]           s_awlen,
    input  logic [2:0]           s_awsize,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [BUS_WIDTH-1:0] s_wid,
    input  logic [31:0]          s_wdata,
    input  logic [3:0]           s_wstrb,
    input  logic                 s_wlast,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    output logic [BUS_WIDTH-1:0] s_bid,
    output logic [1:0]           s_bresp,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    input  logic [BUS_WIDTH-1:0] s_arid,
    input  logic [31:0]          s_araddr,
    input  logic [3:0]           s_arlen,
    input  logic [2:0]           s_arsize,
    input  logic [1:0]           s_arburst,
    input  logic [1:0]           s_arlock,
    input  logic [3:0]           s_arcache,
    input  logic [2:0]           s_arprot,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic [BUS_WIDTH-1:0] s_rid,
    output logic [31:0]          s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rlast,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [BUS_WIDTH-1:0] m_awid,
    output logic [31:0]          m_awaddr,
    output logic [3:0]           m_awlen,
    output logic [2:0]           m_awsize,
    output logic [1:0]           m_awburst,
    output logic [1:0]           m_awlock,
    output logic [3:0]           m_awcache,
    output logic [2:0]           m_awprot,
    output logic                 m_awvalid,
    input  logic                 m_awready,
    output logic [BUS_WIDTH-1:0] m_wid,
    output logic [31:0]          m_wdata,
    output logic [3:0]           m_wstrb,
    output logic                 m_wlast,
    output logic                 m_wvalid,
    input  logic                 m_wready,
    input  logic [BUS_WIDTH-1:0] m_bid,
    input  logic [1:0]           m_bresp,
    input  logic                 m_bvalid,
    output logic                 m_bready,
    output logic [BUS_WIDTH-1:0] m_arid,
    output logic [31:0]          m_araddr,
    output logic [3:0]           m_arlen,
    output logic [2:0]           m_arsize,
    output logic [1:0]           m_arburst,
    output logic [1:0]           m_arlock,
    output logic [3:0]           m_arcache,
    output logic [2:0]           m_arprot,
    output logic                 m_arvalid,
    input  logic                 m_arready,
    input  logic [BUS_WIDTH-1:0] m_rid,
    input  logic [31:0]          m_rdata,
    input  logic [1:0]           m_rresp,
    input  logic                 m_rlast,
    input  logic                 m_rvalid,
    output logic                 m_rready,
    output logic                 wb_empty,
    output logic                 wr_err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] L_DEPTH = DEPTH[PW:0];

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_B} state_t;

    state_t               r_state;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW:0]          r_count;
    logic                 r_aw_done;
    logic                 r_w_done;
    logic                 r_awvalid;
    logic                 r_wvalid;
    logic                 r_bvalid;
    logic [BUS_WIDTH-1:0] r_bid;
    logic                 r_busy;

    logic [BUS_WIDTH-1:0] r_mem_id   [DEPTH];
    logic [31:0]          r_mem_addr [DEPTH];
    logic [2:0]           r_mem_size [DEPTH];
    logic [31:0]          r_mem_data [DEPTH];
    logic [3:0]           r_mem_strb [DEPTH];

    logic w_acc_rdy;
    logic w_push;
    logic w_pop;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_gate;
    logic w_ar_hs;
    logic w_r_end;
    logic w_unused_ok;

    // Holding off while a B response is pending keeps one response register sufficient.
    assign w_acc_rdy = (r_count < L_DEPTH) && !r_bvalid;
    assign w_push    = w_acc_rdy && s_awvalid && s_wvalid;
    assign w_pop     = (r_state == ST_WAIT_B) && m_bvalid;
    assign w_aw_hs   = r_awvalid && m_awready;
    assign w_w_hs    = r_wvalid && m_wready;
    // Reads may only leave when every earlier write has fully completed downstream.
    assign w_gate    = (r_count == '0) && (r_state == ST_IDLE) && !r_busy;
    assign w_ar_hs   = s_arvalid && m_arready && w_gate;
    assign w_r_end   = m_rvalid && s_rready && m_rlast;
    assign w_unused_ok = ^{s_wid, s_awlen, s_wlast, m_bid};

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem_id[r_wr_ptr]   <= s_awid;
            r_mem_addr[r_wr_ptr] <= s_awaddr;
            r_mem_size[r_wr_ptr] <= s_awsize;
            r_mem_data[r_wr_ptr] <= s_wdata;
            r_mem_strb[r_wr_ptr] <= s_wstrb;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_bvalid <= 1'b0;
            r_bid    <= '0;
        end else if (w_push) begin
            r_bvalid <= 1'b1;
            r_bid    <= s_awid;
        end else if (s_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else if (w_ar_hs) begin
            r_busy <= 1'b1;
        end else if (w_r_end) begin
            r_busy <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((r_count != '0) && !r_busy) begin
                        r_state   <= ST_SEND;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    // Both channels may complete in the same cycle; the flags are
                    // cleared here so the next entry starts fresh.
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_state   <= ST_WAIT_B;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                ST_WAIT_B: begin
                    if (m_bvalid) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_awready = w_acc_rdy;
    assign s_wready  = w_acc_rdy;
    assign s_bvalid  = r_bvalid;
    assign s_bid     = r_bid;
    assign s_bresp   = 2'b00;

    assign m_awid    = r_mem_id[r_rd_ptr];
    assign m_awaddr  = r_mem_addr[r_rd_ptr];
    assign m_awlen   = 4'd0;
    assign m_awsize  = r_mem_size[r_rd_ptr];
    assign m_awburst = 2'b01;
    assign m_awlock  = 2'b00;
    assign m_awcache = 4'd0;
    assign m_awprot  = 3'd0;
    assign m_awvalid = r_awvalid;
    assign m_wid     = r_mem_id[r_rd_ptr];
    assign m_wdata   = r_mem_data[r_rd_ptr];
    assign m_wstrb   = r_mem_strb[r_rd_ptr];
    assign m_wlast   = 1'b1;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = 1'b1;

    assign m_arid    = s_arid;
    assign m_araddr  = s_araddr;
    assign m_arlen   = s_arlen;
    assign m_arsize  = s_arsize;
    assign m_arburst = s_arburst;
    assign m_arlock  = s_arlock;
    assign m_arcache = s_arcache;
    assign m_arprot  = s_arprot;
    assign m_arvalid = s_arvalid && w_gate;
    assign s_arready = m_arready && w_gate;

    assign s_rid     = m_rid;
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign s_rvalid  = m_rvalid;
    assign m_rready  = s_rready;

    assign wb_empty  = w_gate;
    // The CPU already received OKAY, so a downstream error is only flagged here.
    assign wr_err    = w_pop && (m_bresp != 2'b00);
endmodule
